// File: rtl/adder_full_adder.sv
// One-bit full-adder cell: the repeating element of the adder's ripple-carry chain.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder.sv
// Parameterised ripple-carry adder with a registered result: {c_out, sum} = a + b + c_in,
// available one clock after the operands are presented.
module adder #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            c_out,
  output logic [size-1:0] sum,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            c_in
);

  logic [size:0]   c;
  logic [size-1:0] sum_comb;

  assign c[0] = c_in;

  // Carry ripples from bit 0 upward; c[size] is the full-width carry-out.
  for (genvar i = 0; i < size; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_comb[i]),
      .cout (c[i+1])
    );
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so
  // ordering between always_ff blocks can never change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_comb;
      c_out <= c[size];
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder (size = 4): directed cases, exhaustive 9-bit sweep and
// asynchronous resets, checked through an expected-result scoreboard queue.
module tb_adder;

  localparam int size_p = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_out;
  logic [size_p-1:0] sum;
  logic [size_p-1:0] a;
  logic [size_p-1:0] b;
  logic              c_in;

  int passed = 0;
  int total  = 0;

  logic [size_p:0] sb_q[$];

  adder #(.size(size_p)) dut (
    .clk   (clk),
    .rst   (rst),
    .c_out (c_out),
    .sum   (sum),
    .a     (a),
    .b     (b),
    .c_in  (c_in)
  );

  always #5 clk = ~clk;

  function automatic logic [size_p:0] model(input logic [size_p-1:0] x,
                                            input logic [size_p-1:0] y,
                                            input logic              ci);
    return (size_p+1)'(x) + (size_p+1)'(y) + (size_p+1)'(ci);
  endfunction

  task automatic check(input string tag, input logic [size_p:0] observed,
                       input logic [size_p:0] expected);
    total++;
    if (observed === expected) passed++;
    else $display("FAIL %s: got {c_out,sum}=0x%0h, expected 0x%0h at %0t",
                  tag, observed, expected, $time);
  endtask

  // Compare the result of the previous operand set, then present a new one.
  task automatic step(input string tag, input logic [size_p-1:0] na,
                      input logic [size_p-1:0] nb, input logic nc);
    @(negedge clk);
    if (sb_q.size() > 0) check(tag, {c_out, sum}, sb_q.pop_front());
    a    = na;
    b    = nb;
    c_in = nc;
    sb_q.push_back(model(na, nb, nc));
  endtask

  initial begin
    rst  = 1'b1;
    a    = 4'hF;
    b    = 4'hF;
    c_in = 1'b1;

    // Reset dominates clock edges even with maximal operands applied.
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", {c_out, sum}, '0);
    end
    rst = 1'b0;
    sb_q.push_back(model(a, b, c_in));

    step("rst_release", 4'h3, 4'h5, 1'b0);
    step("basic",       4'h3, 4'h5, 1'b1);
    step("basic_cin",   4'hF, 4'h1, 1'b0);
    step("wrap",        4'h8, 4'h8, 1'b1);
    step("wrap_cin",    4'hF, 4'h0, 1'b1);
    step("full_prop",   4'h0, 4'h0, 1'b0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step("sweep", v[7:4], v[3:0], v[8]);

      if (i == 200) begin
        // Short pulse between edges: outputs clear at once, pending operands still land.
        #2 rst = 1'b1;
        #1 check("mid_rst_async", {c_out, sum}, '0);
        rst = 1'b0;
      end else if (i == 300) begin
        // Reset held across an edge: in-flight result is discarded.
        #2 rst = 1'b1;
        #1 check("hold_rst_async", {c_out, sum}, '0);
        @(negedge clk);
        check("hold_rst_edge", {c_out, sum}, '0);
        sb_q.delete();
        rst = 1'b0;
        sb_q.push_back(model(a, b, c_in));
      end
    end

    while (sb_q.size() > 0) begin
      @(negedge clk);
      check("drain", {c_out, sum}, sb_q.pop_front());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
